lsu_axi_lite: RTL
=================

Name: lsu_axi_lite

Overview:
- AXI-lite master load/store unit; it replaces the combinational data-memory path downstream of the ALU.
- Accepts one load/store request per transaction from the execute stage: address from ALU result, store data from rs2, MemOP from the control generator.
- Drives AR/R or AW/W/B on the data port of the shared RAM AXI-lite slave.
- Returns sign/zero-extended load data to the register write-back mux, with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, AXI address width (matches instruction address bus width).
- DATA_W, 64, AXI data width; only 64 is supported.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous reset, active-low
- req_valid  in  1  execute stage presents a memory request
- req_ready  out  1  LSU idle, request accepted on valid&ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  64  byte address (ALU result); bits [ADDR_W-1:0] used
- req_wdata  in  64  store data, right-aligned
- req_memop  in  3  access size/sign, lsu_pkg encoding
- done  out  1  one-cycle pulse: transaction complete
- err  out  1  valid with done: misaligned or non-OKAY response
- rdata  out  64  extended load data, valid with done, held until next done
- ARADDR  out  ADDR_W  8-byte-aligned read address
- ARVALID  out  1  read address valid
- ARREADY  in  1  read address ready
- RDATA  in  64  read data
- RRESP  in  2  read response
- RVALID  in  1  read data valid
- RREADY  out  1  read data ready
- AWADDR  out  ADDR_W  8-byte-aligned write address
- AWVALID  out  1  write address valid
- AWREADY  in  1  write address ready
- WDATA  out  64  lane-shifted write data
- WSTRB  out  8  byte enables
- WVALID  out  1  write data valid
- WREADY  in  1  write data ready
- BRESP  in  2  write response
- BVALID  in  1  write response valid
- BREADY  out  1  write response ready

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP, FIN. req_ready = (state==IDLE).
- Reset (async, resetn=0):
  - state=IDLE; all VALID/READY outputs and done/err = 0.
  - rdata=0; captured request registers = 0.
  - Reset mid-transaction abandons the access; the bus slave is reset by the same resetn.
- IDLE:
  - On req_valid, capture we/addr/wdata/memop.
  - If misaligned (halfword addr[0]!=0; word addr[1:0]!=0; double addr[2:0]!=0) -> FIN with err=1, no bus traffic.
  - Else load -> RADDR; store -> WREQ.
- RADDR: ARVALID=1, ARADDR={addr[ADDR_W-1:3],3'b0}, held stable until ARREADY; then -> RDATA.
- RDATA:
  - RREADY=1. On RVALID: lane = RDATA >> (8*addr[2:0]).
  - Extend lane per memop into rdata register; err = (RRESP!=2'b00); -> FIN.
- WREQ:
  - AWVALID and WVALID asserted together on entry.
  - Each drops the cycle after its own handshake; both may complete in the same or different cycles.
  - When both are done -> WRESP.
  - WDATA = wdata << (8*addr[2:0]).
  - WSTRB = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
- WRESP: BREADY=1; on BVALID, err = (BRESP!=2'b00) -> FIN.
- FIN: done=1 for exactly one cycle -> IDLE. req_ready is 0 in FIN, so the minimum request spacing is one idle cycle.
- Latency: load with zero-wait slave = accept(T) -> ARVALID T+1 -> RVALID T+2 -> done T+3.
- Stores: rdata unchanged. Misaligned: rdata unchanged, err=1.
- Request held high while busy is ignored, not queued.
- Address/data outputs hold their last value when the corresponding VALID is low.

Decomposition:
- lsu_pkg holds:
  - MemOP encoding: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110; stores use memop[1:0] for size.
  - State enum.
  - AXI response constants OKAY=2'b00, SLVERR=2'b10.
- One sub-module, lsu_lane_align: combinational strobe/shift generation for stores and extract/extend for loads, keyed by addr[2:0] and memop. The FSM stays in lsu_axi_lite.

Test Plan:
- LB at addr 0x8000_0003, slave returns RDATA=0x0000_0000_8000_0000 with zero wait -> ARADDR=0x8000_0000, rdata=0xFFFF_FFFF_FFFF_FF80, done at T+3, err=0.
- LHU at 0x8000_0006, RDATA=0xBEEF_0000_0000_0000 -> rdata=0x0000_0000_0000_BEEF.
- SW of 0x1234_5678 at 0x8000_0004 with AWREADY at +1 and WREADY at +3 -> AWADDR=0x8000_0000, WSTRB=0xF0, WDATA=0x1234_5678_0000_0000; each VALID drops after its own handshake; done after BVALID, err=0.
- LD at 0x8000_0004 (misaligned) -> no ARVALID ever, done next cycle with err=1, rdata unchanged.
- Load with RRESP=2'b10 -> done with err=1. Store with BRESP=2'b10 -> err=1.
- resetn pulled low while ARVALID=1 with ARREADY stalled -> ARVALID=0 immediately; after release, req_ready=1 and a new LW at 0x8000_0000 completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the AXI-lite load/store unit: MemOP encoding,
// FSM states, AXI response codes and the alignment rule.
package lsu_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LD  = 3'b011;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;
    localparam logic [2:0] MEMOP_LWU = 3'b110;

    // memop[1:0] is the access size for both loads and stores
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WREQ,
        ST_WRESP,
        ST_FIN
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        logic mis;
        case (size)
            SIZE_H:  mis = off[0];
            SIZE_W:  mis = |off[1:0];
            SIZE_D:  mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_axi_lite_if.sv
// AXI-lite read/write channel bundle between the LSU (master) and the
// shared RAM data port (slave).
interface lsu_axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY,
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY
    );

    modport slave (
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY,
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 64-bit data port: store strobe/shift generation
// and load extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_off,
    input  logic [2:0]  i_memop,
    input  logic [63:0] i_st_data,
    input  logic [63:0] i_ld_word,
    output logic [63:0] o_st_data,
    output logic [7:0]  o_st_strb,
    output logic [63:0] o_ld_data
);
    logic [5:0]  w_shamt;
    logic [3:0]  w_nbytes;
    logic [63:0] w_lane;
    logic        w_sext;

    assign w_shamt   = {i_off, 3'b000};
    assign w_nbytes  = 4'd1 << i_memop[1:0];
    assign o_st_data = i_st_data << w_shamt;
    assign w_lane    = i_ld_word >> w_shamt;
    assign w_sext    = ~i_memop[2];

    // A lane is enabled when it falls inside [off, off+size); aligned
    // accesses never cross the 8-byte boundary.
    for (genvar gi = 0; gi < 8; gi++) begin : g_strb
        assign o_st_strb[gi] = (4'(gi) >= {1'b0, i_off}) &&
                               (4'(gi) <  ({1'b0, i_off} + w_nbytes));
    end

    always_comb begin
        o_ld_data = w_lane;
        case (i_memop[1:0])
            SIZE_B:  o_ld_data = {{56{w_lane[7]  & w_sext}}, w_lane[7:0]};
            SIZE_H:  o_ld_data = {{48{w_lane[15] & w_sext}}, w_lane[15:0]};
            SIZE_W:  o_ld_data = {{32{w_lane[31] & w_sext}}, w_lane[31:0]};
            default: o_ld_data = w_lane;
        endcase
    end

endmodule

// File: rtl/lsu_axi_lite.sv
// AXI-lite master load/store unit: one request at a time from execute,
// single-beat read or write on the RAM data port, extended load data back.
module lsu_axi_lite
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_memop,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    lsu_axi_lite_if.master    axi
);
    lsu_state_e          r_state;
    lsu_state_e          w_state_next;

    logic [2:0]          r_off;
    logic [2:0]          r_memop;
    logic [ADDR_W-1:0]   r_araddr;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_aw_pend;
    logic                r_w_pend;
    logic                r_err;

    logic                w_accept;
    logic                w_mis;
    logic [ADDR_W-1:0]   w_line_addr;
    logic [2:0]          w_off;
    logic [2:0]          w_memop;
    logic [DATA_W-1:0]   w_st_data;
    logic [DATA_W/8-1:0] w_st_strb;
    logic [DATA_W-1:0]   w_ld_data;
    logic                w_aw_done;
    logic                w_w_done;
    logic                w_unused_addr;

    assign w_accept      = (r_state == ST_IDLE) && req_valid;
    assign w_mis         = is_misaligned(req_addr[2:0], req_memop[1:0]);
    assign w_line_addr   = {req_addr[ADDR_W-1:3], 3'b000};
    assign w_unused_addr = ^req_addr[63:ADDR_W];
    assign w_aw_done     = !r_aw_pend || axi.AWREADY;
    assign w_w_done      = !r_w_pend  || axi.WREADY;

    // Store steering is needed at accept time, load extraction later from
    // the captured offset/memop, so one aligner serves both.
    assign w_off   = (r_state == ST_IDLE) ? req_addr[2:0] : r_off;
    assign w_memop = (r_state == ST_IDLE) ? req_memop     : r_memop;

    lsu_lane_align u_align (
        .i_off     (w_off),
        .i_memop   (w_memop),
        .i_st_data (req_wdata),
        .i_ld_word (axi.RDATA),
        .o_st_data (w_st_data),
        .o_st_strb (w_st_strb),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        axi.ARVALID  = 1'b0;
        axi.RREADY   = 1'b0;
        axi.BREADY   = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_mis)       w_state_next = ST_FIN;
                    else if (req_we) w_state_next = ST_WREQ;
                    else             w_state_next = ST_RADDR;
                end
            end
            ST_RADDR: begin
                axi.ARVALID = 1'b1;
                if (axi.ARREADY) w_state_next = ST_RDATA;
            end
            ST_RDATA: begin
                axi.RREADY = 1'b1;
                if (axi.RVALID) w_state_next = ST_FIN;
            end
            ST_WREQ: begin
                if (w_aw_done && w_w_done) w_state_next = ST_WRESP;
            end
            ST_WRESP: begin
                axi.BREADY = 1'b1;
                if (axi.BVALID) w_state_next = ST_FIN;
            end
            ST_FIN: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bus address/data registers load only when a transfer will actually be
    // issued, so they keep their last value while the matching VALID is low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_off     <= '0;
            r_memop   <= '0;
            r_araddr  <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_off     <= req_addr[2:0];
                r_memop   <= req_memop;
                r_err     <= w_mis;
                r_aw_pend <= req_we && !w_mis;
                r_w_pend  <= req_we && !w_mis;
                if (!w_mis && req_we) begin
                    r_awaddr <= w_line_addr;
                    r_wdata  <= w_st_data;
                    r_wstrb  <= w_st_strb;
                end
                if (!w_mis && !req_we) begin
                    r_araddr <= w_line_addr;
                end
            end
            if (r_state == ST_RDATA && axi.RVALID) begin
                r_rdata <= w_ld_data;
                r_err   <= (axi.RRESP != RESP_OKAY);
            end
            if (r_state == ST_WREQ) begin
                if (axi.AWREADY) r_aw_pend <= 1'b0;
                if (axi.WREADY)  r_w_pend  <= 1'b0;
            end
            if (r_state == ST_WRESP && axi.BVALID) begin
                r_err <= (axi.BRESP != RESP_OKAY);
            end
        end
    end

    assign axi.ARADDR  = r_araddr;
    assign axi.AWADDR  = r_awaddr;
    assign axi.AWVALID = r_aw_pend;
    assign axi.WDATA   = r_wdata;
    assign axi.WSTRB   = r_wstrb;
    assign axi.WVALID  = r_w_pend;
    assign err         = r_err;
    assign rdata       = r_rdata;

endmodule
